step_sequencer: RTL and testbench
=================================

Name: step_sequencer

Overview:
- Move scheduler between the SPI command FSM and the stepper drivers (DualHBridge / microstepper_top).
- Accepts move commands through a valid/ready port into a 2-entry command buffer.
- Sequences direction setup, step pulse width and inter-step period (with per-step period ramp), and drives step/dir/enable.
- Flags buffer space (buffer_dtr) and move completion (move_done).

Parameters:
- TICK_BITS, 32, width of period/delta fields (clk cycles).
- STEPS_BITS, 32, width of step count field.
- DIR_SETUP, 16, clk cycles dir is stable before the first step edge after a dir change.
- STEP_PULSE, 32, clk cycles step is held high per step.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  buffer can accept; transfer when cmd_valid & cmd_ready on clk rise
- cmd_steps  in  STEPS_BITS  steps in move (unsigned)
- cmd_dir  in  1  direction for move
- cmd_period  in  TICK_BITS  initial step period, clk cycles, rising edge to rising edge
- cmd_delta  in  TICK_BITS  signed per-step period adjustment
- enable_in  in  1  driver enable request
- halt  in  1  abort request, level
- step  out  1  step pulse
- dir  out  1  direction
- enable  out  1  registered enable_in
- buffer_dtr  out  1  buffer not full
- move_done  out  1  one-cycle pulse at end of each completed move
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, resetn=0): buffer empty, state IDLE, step=0, dir=0, enable=0, move_done=0, busy=0. cmd_ready=buffer_dtr=1 once combinationally derived from the empty buffer.
- Buffer: 2-entry FIFO.
  - cmd_ready = buffer_dtr = !full.
  - A push when full is impossible (ready low).
  - Pop occurs only in LOAD.
- States: IDLE, LOAD, DIRSET, PULSE, WAIT.
- IDLE: to LOAD when buffer non-empty & enable_in & !halt.
- LOAD (1 cycle): pop and latch remaining=cmd_steps, period=max(cmd_period, STEP_PULSE+1), delta.
  - steps==0: move_done pulse next cycle, then next-move rule.
  - cmd_dir != dir: dir updates this cycle, go to DIRSET for exactly DIR_SETUP cycles.
  - Otherwise go to PULSE.
- PULSE: step=1 for STEP_PULSE cycles; period counter starts at the step rising edge. Then go to WAIT with remaining-1.
- WAIT: step=0 until the counter reaches period.
  - Each step: period <= period + delta, saturating to [STEP_PULSE+1, 2^TICK_BITS-1].
  - remaining!=0: go to PULSE.
  - remaining==0: move_done=1 for one cycle, then next-move rule.
- Next-move rule: buffer non-empty & enable_in: go to LOAD directly, with no gap beyond the LOAD cycle. Otherwise go to IDLE.
- enable: register of enable_in, 1-cycle latency.
- enable_in low during a move: the current pulse completes, then the sequencer holds in WAIT (counter frozen) until enable_in returns.
- halt:
  - Asserted in PULSE: the pulse completes its full width (never truncated).
  - Otherwise, or once the pulse completes: go to IDLE next cycle and flush the buffer. No move_done is issued for an aborted move.
  - While halt is held, the buffer is flushed every cycle and cmd_ready stays as !full of the flushed buffer, so pushes are discarded.
- dir is retained across moves and changes only in LOAD.
- Simultaneous push and pop in LOAD: both occur; occupancy unchanged.

Optional Feature:
- SEQ_POSITION_EN
- Defined: adds output position (signed 64 bits), reset 0. Incremented (dir=1) or decremented (dir=0) on each step rising edge; wraps in two's complement. A halt does not alter it.
- Undefined: port absent, no counter logic.

Test Plan:
- Push {steps=3, dir=0, period=100, delta=0}, enable_in=1 → 3 step pulses 32 cycles high, rising edges 100 cycles apart, dir stays 0 (no DIRSET), one move_done pulse after the third period.
- Push {5, dir=1, period=200, delta=-50} → DIRSET 16 cycles after LOAD, then intervals 200, 150, 100, 50, 33 (saturated at STEP_PULSE+1); move_done once.
- Push three commands back-to-back with the sequencer disabled → cmd_ready/buffer_dtr fall after 2 accepted; third held until the first LOAD, then accepted. Moves run back-to-back with only the LOAD cycle between them.
- Assert halt 10 cycles into a PULSE of a 100-step move with 1 command buffered → step stays high the full 32 cycles, then IDLE, buffer empty, no move_done.
- Push {steps=0} → no step, move_done 2 cycles after acceptance. Assert resetn=0 mid-PULSE → step=0 immediately, buffer empty.
- With SEQ_POSITION_EN: 4 steps dir=1 then 6 steps dir=0 → position reads -2.

Source files
------------

// File: rtl/step_sequencer.sv
// Move scheduler: buffers up to two move commands and sequences dir setup, step pulses and a ramped step period.
// Optional feature: define SEQ_POSITION_EN to add a signed 64-bit step position output.

module step_sequencer #(
    parameter int TICK_BITS  = 32,
    parameter int STEPS_BITS = 32,
    parameter int DIR_SETUP  = 16,
    parameter int STEP_PULSE = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [STEPS_BITS-1:0] cmd_steps,
    input  logic                  cmd_dir,
    input  logic [TICK_BITS-1:0]  cmd_period,
    input  logic [TICK_BITS-1:0]  cmd_delta,
    input  logic                  enable_in,
    input  logic                  halt,
    output logic                  step,
    output logic                  dir,
    output logic                  enable,
    output logic                  buffer_dtr,
    output logic                  move_done,
    output logic                  busy
`ifdef SEQ_POSITION_EN
    ,
    output logic signed [63:0]    position
`endif
);

    localparam logic [TICK_BITS-1:0]  MIN_PERIOD  = TICK_BITS'(STEP_PULSE + 1);
    localparam logic [TICK_BITS-1:0]  PULSE_LAST  = TICK_BITS'(STEP_PULSE - 1);
    localparam logic [TICK_BITS-1:0]  DIRSET_LAST = TICK_BITS'(DIR_SETUP - 1);
    localparam logic [TICK_BITS-1:0]  ONE_TICK    = TICK_BITS'(1);
    localparam logic [STEPS_BITS-1:0] ONE_STEP    = STEPS_BITS'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIRSET,
        PULSE,
        WAIT
    } state_t;

    state_t state;

    logic [STEPS_BITS-1:0] fifo_steps  [2];
    logic                  fifo_dir    [2];
    logic [TICK_BITS-1:0]  fifo_period [2];
    logic [TICK_BITS-1:0]  fifo_delta  [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic [1:0]            count_next;
    logic                  full;
    logic                  push;
    logic                  pop;

    logic [STEPS_BITS-1:0] head_steps;
    logic                  head_dir;
    logic [TICK_BITS-1:0]  head_period;
    logic [TICK_BITS-1:0]  head_delta;

    logic [STEPS_BITS-1:0] remaining;
    logic [TICK_BITS-1:0]  period;
    logic [TICK_BITS-1:0]  delta;
    logic [TICK_BITS-1:0]  tick;
    logic                  halt_seen;
    logic                  period_end;
    logic                  next_move;
    logic                  step_start;

    assign full       = (count == 2'd2);
    assign cmd_ready  = !full;
    assign buffer_dtr = !full;
    assign push       = cmd_valid && !full && !halt;
    assign pop        = (state == LOAD);
    assign busy       = (state != IDLE);

    assign head_steps  = fifo_steps[rd_ptr];
    assign head_dir    = fifo_dir[rd_ptr];
    assign head_period = fifo_period[rd_ptr];
    assign head_delta  = fifo_delta[rd_ptr];

    assign period_end = (tick == period - ONE_TICK);
    assign next_move  = (count_next != 2'd0) && enable_in && !halt;

    // Every path that raises step, shared by the FSM and the position counter.
    assign step_start = ((state == LOAD) && !halt && (head_steps != '0) && (head_dir == dir)) ||
                        ((state == DIRSET) && !halt && (tick == DIRSET_LAST)) ||
                        ((state == WAIT) && !halt && enable_in && period_end && (remaining != '0));

    // Halt flushes the whole buffer every cycle it is held, discarding any concurrent push.
    always_comb begin
        count_next = count;
        if (halt) begin
            count_next = 2'd0;
        end else if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_steps[wr_ptr]  <= cmd_steps;
            fifo_dir[wr_ptr]    <= cmd_dir;
            fifo_period[wr_ptr] <= cmd_period;
            fifo_delta[wr_ptr]  <= cmd_delta;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            count <= count_next;
            if (halt) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (push) wr_ptr <= !wr_ptr;
                if (pop)  rd_ptr <= !rd_ptr;
            end
        end
    end

    function automatic logic [TICK_BITS-1:0] ramp(input logic [TICK_BITS-1:0] p,
                                                   input logic [TICK_BITS-1:0] d);
        logic signed [TICK_BITS+1:0] sum;
        sum = $signed({2'b00, p}) + $signed({{2{d[TICK_BITS-1]}}, d});
        if (sum < $signed({2'b00, MIN_PERIOD})) begin
            return MIN_PERIOD;
        end else if (sum > $signed({2'b00, {TICK_BITS{1'b1}}})) begin
            return {TICK_BITS{1'b1}};
        end else begin
            return sum[TICK_BITS-1:0];
        end
    endfunction

    // tick counts from the step rising edge so a period spans PULSE plus WAIT.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            step      <= 1'b0;
            dir       <= 1'b0;
            enable    <= 1'b0;
            move_done <= 1'b0;
            remaining <= '0;
            period    <= MIN_PERIOD;
            delta     <= '0;
            tick      <= '0;
            halt_seen <= 1'b0;
        end else begin
            enable    <= enable_in;
            move_done <= 1'b0;
            case (state)
                IDLE: begin
                    if ((count != 2'd0) && enable_in && !halt) state <= LOAD;
                end
                LOAD: begin
                    remaining <= head_steps;
                    period    <= (head_period < MIN_PERIOD) ? MIN_PERIOD : head_period;
                    delta     <= head_delta;
                    tick      <= '0;
                    halt_seen <= 1'b0;
                    if (halt) begin
                        state <= IDLE;
                    end else if (head_steps == '0) begin
                        move_done <= 1'b1;
                        state     <= next_move ? LOAD : IDLE;
                    end else if (head_dir != dir) begin
                        dir   <= head_dir;
                        state <= DIRSET;
                    end else begin
                        step  <= 1'b1;
                        state <= PULSE;
                    end
                end
                DIRSET: begin
                    if (halt) begin
                        state <= IDLE;
                    end else if (step_start) begin
                        step  <= 1'b1;
                        tick  <= '0;
                        state <= PULSE;
                    end else begin
                        tick <= tick + ONE_TICK;
                    end
                end
                PULSE: begin
                    tick <= tick + ONE_TICK;
                    if (halt) halt_seen <= 1'b1;
                    if (tick == PULSE_LAST) begin
                        step      <= 1'b0;
                        remaining <= remaining - ONE_STEP;
                        state     <= (halt || halt_seen) ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (halt) begin
                        state <= IDLE;
                    end else if (enable_in) begin
                        if (period_end) begin
                            period <= ramp(period, delta);
                            if (step_start) begin
                                step  <= 1'b1;
                                tick  <= '0;
                                state <= PULSE;
                            end else begin
                                move_done <= 1'b1;
                                state     <= next_move ? LOAD : IDLE;
                            end
                        end else begin
                            tick <= tick + ONE_TICK;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_POSITION_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            position <= '0;
        end else if (step_start) begin
            position <= dir ? position + 64'sd1 : position - 64'sd1;
        end
    end
`endif

endmodule

// File: tb/tb_step_sequencer.sv
// Directed self-checking bench for step_sequencer: timing of pulses, ramp, buffering, halt and reset.
// Define SEQ_POSITION_EN to also exercise the position counter.

module tb_step_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_steps;
    logic        cmd_dir;
    logic [31:0] cmd_period;
    logic [31:0] cmd_delta;
    logic        enable_in;
    logic        halt;
    logic        step;
    logic        dir;
    logic        enable;
    logic        buffer_dtr;
    logic        move_done;
    logic        busy;
`ifdef SEQ_POSITION_EN
    logic signed [63:0] position;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int rise_q[$];
    int fall_q[$];
    int done_q[$];
    int dir_chg_cyc = -1;
    logic step_q = 1'b0;
    logic dir_q = 1'b0;

    step_sequencer dut (
        .clk        (clk),
        .resetn     (resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_dir    (cmd_dir),
        .cmd_period (cmd_period),
        .cmd_delta  (cmd_delta),
        .enable_in  (enable_in),
        .halt       (halt),
        .step       (step),
        .dir        (dir),
        .enable     (enable),
        .buffer_dtr (buffer_dtr),
        .move_done  (move_done),
        .busy       (busy)
`ifdef SEQ_POSITION_EN
        ,
        .position   (position)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle; entries hold the index of the edge that produced them.
    always @(negedge clk) begin
        if (resetn) begin
            if (step && !step_q) rise_q.push_back(cyc);
            if (!step && step_q) fall_q.push_back(cyc);
            if (move_done) done_q.push_back(cyc);
            if (dir != dir_q) dir_chg_cyc = cyc;
        end
        step_q = step;
        dir_q  = dir;
    end

    task automatic clear_log();
        rise_q.delete();
        fall_q.delete();
        done_q.delete();
        dir_chg_cyc = -1;
    endtask

    task automatic push_cmd(input logic [31:0] s, input logic d, input logic [31:0] p,
                            input logic [31:0] dl, output int acc);
        int waited = 0;
        @(negedge clk);
        cmd_steps  = s;
        cmd_dir    = d;
        cmd_period = p;
        cmd_delta  = dl;
        cmd_valid  = 1'b1;
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("[TB] FAIL push_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        acc = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rise(output int r);
        int n = 0;
        while (rise_q.size() == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rise_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL rise_timeout: rises=0 required >=1");
            r = -1000;
        end else begin
            r = rise_q[0];
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (step !== 1'b0) begin errors++; $display("[TB] FAIL reset_step: got %0b required 0", step); end
        if (dir !== 1'b0) begin errors++; $display("[TB] FAIL reset_dir: got %0b required 0", dir); end
        if (enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable: got %0b required 0", enable); end
        if (move_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b required 0", move_done); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b required 0", busy); end
        if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0b required 1", cmd_ready); end
        if (buffer_dtr !== 1'b1) begin errors++; $display("[TB] FAIL reset_dtr: got %0b required 1", buffer_dtr); end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_move();
        int a;
        enable_in = 1'b1;
        @(negedge clk);
        clear_log();
        push_cmd(32'd3, 1'b0, 32'd100, 32'd0, a);
        repeat (320) @(negedge clk);
        checks += 4;
        if (rise_q.size() !== 3) begin errors++; $display("[TB] FAIL basic_rises: got %0d required 3", rise_q.size()); end
        if (done_q.size() !== 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d required 1", done_q.size()); end
        if (dir !== 1'b0) begin errors++; $display("[TB] FAIL basic_dir: got %0b required 0", dir); end
        if (dir_chg_cyc !== -1) begin errors++; $display("[TB] FAIL basic_dir_change: got %0d required -1", dir_chg_cyc); end
        if (rise_q.size() == 3 && fall_q.size() == 3 && done_q.size() == 1) begin
            checks += 5;
            if (rise_q[0] !== a + 2) begin errors++; $display("[TB] FAIL basic_first_rise: got %0d required %0d", rise_q[0], a + 2); end
            if (rise_q[1] - rise_q[0] !== 100) begin errors++; $display("[TB] FAIL basic_interval1: got %0d required 100", rise_q[1] - rise_q[0]); end
            if (rise_q[2] - rise_q[1] !== 100) begin errors++; $display("[TB] FAIL basic_interval2: got %0d required 100", rise_q[2] - rise_q[1]); end
            if (fall_q[2] - rise_q[2] !== 32) begin errors++; $display("[TB] FAIL basic_width: got %0d required 32", fall_q[2] - rise_q[2]); end
            if (done_q[0] !== rise_q[2] + 100) begin errors++; $display("[TB] FAIL basic_done_time: got %0d required %0d", done_q[0], rise_q[2] + 100); end
        end
    endtask

    task automatic test_ramp_dir();
        int a;
        int exp_iv[4] = '{200, 150, 100, 50};
        clear_log();
        push_cmd(32'd5, 1'b1, 32'd200, -32'sd50, a);
        repeat (580) @(negedge clk);
        checks += 3;
        if (rise_q.size() !== 5) begin errors++; $display("[TB] FAIL ramp_rises: got %0d required 5", rise_q.size()); end
        if (done_q.size() !== 1) begin errors++; $display("[TB] FAIL ramp_done_count: got %0d required 1", done_q.size()); end
        if (dir_chg_cyc !== a + 2) begin errors++; $display("[TB] FAIL ramp_dir_change: got %0d required %0d", dir_chg_cyc, a + 2); end
        if (rise_q.size() == 5 && done_q.size() == 1) begin
            checks += 2;
            if (rise_q[0] - dir_chg_cyc !== 16) begin errors++; $display("[TB] FAIL ramp_dirset: got %0d required 16", rise_q[0] - dir_chg_cyc); end
            if (done_q[0] - rise_q[4] !== 33) begin errors++; $display("[TB] FAIL ramp_last_interval: got %0d required 33", done_q[0] - rise_q[4]); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rise_q[i+1] - rise_q[i] !== exp_iv[i]) begin
                    errors++;
                    $display("[TB] FAIL ramp_interval%0d: got %0d required %0d", i, rise_q[i+1] - rise_q[i], exp_iv[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int a;
        int n;
        enable_in = 1'b0;
        push_cmd(32'd2, 1'b1, 32'd40, 32'd0, a);
        push_cmd(32'd2, 1'b1, 32'd40, 32'd0, a);
        @(negedge clk);
        cmd_steps  = 32'd2;
        cmd_dir    = 1'b1;
        cmd_period = 32'd40;
        cmd_delta  = 32'd0;
        cmd_valid  = 1'b1;
        checks += 2;
        if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_full: got %0b required 0", cmd_ready); end
        if (buffer_dtr !== 1'b0) begin errors++; $display("[TB] FAIL b2b_dtr_full: got %0b required 0", buffer_dtr); end
        repeat (5) @(negedge clk);
        checks += 2;
        if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_held: got %0b required 0", cmd_ready); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_disabled: got %0b required 0", busy); end
        clear_log();
        enable_in = 1'b1;
        n = cyc;
        push_cmd(32'd2, 1'b1, 32'd40, 32'd0, a);
        checks++;
        if (a !== n + 3) begin errors++; $display("[TB] FAIL b2b_third_accept: got %0d required %0d", a, n + 3); end
        repeat (260) @(negedge clk);
        checks += 3;
        if (rise_q.size() !== 6) begin errors++; $display("[TB] FAIL b2b_rises: got %0d required 6", rise_q.size()); end
        if (done_q.size() !== 3) begin errors++; $display("[TB] FAIL b2b_done_count: got %0d required 3", done_q.size()); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_end: got %0b required 0", busy); end
        if (rise_q.size() == 6 && done_q.size() == 3) begin
            checks += 4;
            if (rise_q[0] !== n + 2) begin errors++; $display("[TB] FAIL b2b_first_rise: got %0d required %0d", rise_q[0], n + 2); end
            if (rise_q[2] - done_q[0] !== 1) begin errors++; $display("[TB] FAIL b2b_gap1: got %0d required 1", rise_q[2] - done_q[0]); end
            if (rise_q[4] - done_q[1] !== 1) begin errors++; $display("[TB] FAIL b2b_gap2: got %0d required 1", rise_q[4] - done_q[1]); end
            if (done_q[2] !== n + 244) begin errors++; $display("[TB] FAIL b2b_last_done: got %0d required %0d", done_q[2], n + 244); end
        end
    endtask

    task automatic test_halt();
        int a;
        int r;
        clear_log();
        push_cmd(32'd100, 1'b1, 32'd100, 32'd0, a);
        push_cmd(32'd5, 1'b1, 32'd100, 32'd0, a);
        wait_rise(r);
        while (cyc < r + 10) @(negedge clk);
        halt = 1'b1;
        while (cyc < r + 31) @(negedge clk);
        checks += 2;
        if (step !== 1'b1) begin errors++; $display("[TB] FAIL halt_pulse_held: got %0b required 1", step); end
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL halt_busy_in_pulse: got %0b required 1", busy); end
        @(negedge clk);
        checks += 2;
        if (step !== 1'b0) begin errors++; $display("[TB] FAIL halt_pulse_end: got %0b required 0", step); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL halt_idle: got %0b required 0", busy); end
        repeat (5) @(negedge clk);
        halt = 1'b0;
        repeat (20) @(negedge clk);
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL halt_flushed: busy=%0b required 0", busy); end
        if (rise_q.size() !== 1) begin errors++; $display("[TB] FAIL halt_rises: got %0d required 1", rise_q.size()); end
        if (done_q.size() !== 0) begin errors++; $display("[TB] FAIL halt_no_done: got %0d required 0", done_q.size()); end
        if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL halt_ready: got %0b required 1", cmd_ready); end
    endtask

    task automatic test_zero_steps();
        int a;
        clear_log();
        push_cmd(32'd0, 1'b1, 32'd100, 32'd0, a);
        repeat (10) @(negedge clk);
        checks += 3;
        if (done_q.size() !== 1) begin errors++; $display("[TB] FAIL zero_done_count: got %0d required 1", done_q.size()); end
        if (rise_q.size() !== 0) begin errors++; $display("[TB] FAIL zero_rises: got %0d required 0", rise_q.size()); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %0b required 0", busy); end
        if (done_q.size() == 1) begin
            checks++;
            if (done_q[0] !== a + 2) begin errors++; $display("[TB] FAIL zero_done_time: got %0d required %0d", done_q[0], a + 2); end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int a;
        int r;
        clear_log();
        push_cmd(32'd10, 1'b1, 32'd100, 32'd0, a);
        push_cmd(32'd10, 1'b1, 32'd100, 32'd0, a);
        wait_rise(r);
        while (cyc < r + 5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks += 4;
        if (step !== 1'b0) begin errors++; $display("[TB] FAIL rst_step: got %0b required 0", step); end
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %0b required 0", busy); end
        if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_ready: got %0b required 1", cmd_ready); end
        if (dir !== 1'b0) begin errors++; $display("[TB] FAIL rst_dir: got %0b required 0", dir); end
        @(negedge clk);
        resetn = 1'b1;
        repeat (20) @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_buffer_empty: busy=%0b required 0", busy); end
        if (rise_q.size() !== 1) begin errors++; $display("[TB] FAIL rst_rises: got %0d required 1", rise_q.size()); end
    endtask

`ifdef SEQ_POSITION_EN
    task automatic test_position();
        int a;
        checks++;
        if (position !== 64'sd0) begin errors++; $display("[TB] FAIL pos_reset: got %0d required 0", position); end
        push_cmd(32'd4, 1'b1, 32'd40, 32'd0, a);
        push_cmd(32'd6, 1'b0, 32'd40, 32'd0, a);
        repeat (700) @(negedge clk);
        checks++;
        if (position !== -64'sd2) begin errors++; $display("[TB] FAIL pos_final: got %0d required -2", position); end
    endtask
`endif

    initial begin
        cmd_valid  = 1'b0;
        cmd_steps  = '0;
        cmd_dir    = 1'b0;
        cmd_period = '0;
        cmd_delta  = '0;
        enable_in  = 1'b0;
        halt       = 1'b0;
        test_reset();
        test_basic_move();
        test_ramp_dir();
        test_back_to_back();
        test_halt();
        test_zero_steps();
        test_reset_mid_pulse();
`ifdef SEQ_POSITION_EN
        test_position();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
